// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states,
// datapath mux selects and the bundled control-line struct.
package multicycle_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_BNEEX   = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JEX     = 4'd12,
      S_ILLEGAL = 4'd13
   } state_t;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_if_zero;
      logic       pc_write_if_nonzero;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational decode of FSM state (plus memory-ready in FETCH) into the
// datapath control lines; everything is held low while reset is asserted.
module control_decode
   import multicycle_pkg::*;
(
   input  logic   rst_i,
   input  state_t state_i,
   input  logic   mem_rdy_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      if (!rst_i) begin
         case (state_i)
            S_FETCH: begin
               ctrl_o.mem_read  = 1'b1;
               ctrl_o.alu_src_b = SRCB_FOUR;
               // IR load and PC+4 commit only in the cycle the fetch completes
               ctrl_o.ir_write  = mem_rdy_i;
               ctrl_o.pc_write  = mem_rdy_i;
            end
            S_DECODE:  ctrl_o.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
               ctrl_o.mem_read = 1'b1;
               ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               ctrl_o.mem_write = 1'b1;
               ctrl_o.iord      = 1'b1;
            end
            S_RTYPEEX: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = SRCB_B;
               ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.reg_dst   = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
               ctrl_o.alu_src_a           = 1'b1;
               ctrl_o.alu_op              = ALUOP_SUB;
               ctrl_o.pc_source           = PCSRC_ALUOUT;
               ctrl_o.pc_write_if_zero    = (state_i == S_BEQEX);
               ctrl_o.pc_write_if_nonzero = (state_i == S_BNEEX);
            end
            S_ADDIEX: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:  ctrl_o.reg_write = 1'b1;
            S_JEX: begin
               ctrl_o.pc_write  = 1'b1;
               ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ILLEGAL: ctrl_o.illegal_op = 1'b1;
            default:   ctrl_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences one
// instruction at a time and counts retired instructions.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int MEM_WAIT_EN = 1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             memReady,
   output logic             PCWrite,
   output logic             PCWriteIfZero,
   output logic             PCWriteIfNonZero,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             illegalOp,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             mem_rdy;
   logic             retire;
   ctrl_t            ctrl;

   assign mem_rdy = (MEM_WAIT_EN != 0) ? memReady : 1'b1;

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_BNE:       state_d = S_BNEEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         // IR is stable here, so op still selects load versus store
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : ((op == OP_LW) ? S_MEMRD : S_FETCH);
         S_MEMRD:   if (mem_rdy) state_d = S_MEMWB;
         S_MEMWR: begin
            if (mem_rdy) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_MEMWB, S_RTYPEWB, S_BEQEX, S_BNEEX, S_ADDIWB, S_JEX: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ILLEGAL: state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   control_decode u_decode (
      .rst_i     (reset),
      .state_i   (state_q),
      .mem_rdy_i (mem_rdy),
      .ctrl_o    (ctrl)
   );

   assign PCWrite          = ctrl.pc_write;
   assign PCWriteIfZero    = ctrl.pc_write_if_zero;
   assign PCWriteIfNonZero = ctrl.pc_write_if_nonzero;
   assign IorD             = ctrl.iord;
   assign MemRead          = ctrl.mem_read;
   assign MemWrite         = ctrl.mem_write;
   assign IRWrite          = ctrl.ir_write;
   assign MemtoReg         = ctrl.mem_to_reg;
   assign RegDst           = ctrl.reg_dst;
   assign RegWrite         = ctrl.reg_write;
   assign ALUSrcA          = ctrl.alu_src_a;
   assign ALUSrcB          = ctrl.alu_src_b;
   assign ALUOp            = ctrl.alu_op;
   assign PCSource         = ctrl.pc_source;
   assign illegalOp        = ctrl.illegal_op;
   assign state            = state_q;
   assign retired          = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle sequences from a
// reference model feed a per-cycle expected queue compared by a monitor.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op;
   logic        memReady;
   logic        PCWrite, PCWriteIfZero, PCWriteIfNonZero, IorD, MemRead, MemWrite;
   logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegalOp;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic [3:0]  state;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;
   logic [31:0] retired_m = '0;
   logic [53:0] exp_q[$];
   logic [6:0]  drv_q[$];
   logic [53:0] act_vec;

   // clock / reset
   always #5 clk = ~clk;

   multicycle_control #(.MEM_WAIT_EN(1), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .op(op), .memReady(memReady),
      .PCWrite(PCWrite), .PCWriteIfZero(PCWriteIfZero), .PCWriteIfNonZero(PCWriteIfNonZero),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .illegalOp(illegalOp),
      .state(state), .retired(retired)
   );

   assign act_vec = {state, PCWrite, PCWriteIfZero, PCWriteIfNonZero, IorD, MemRead, MemWrite,
                     IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                     illegalOp, retired};

   // Expected control lines for one cycle spent in step s of an instruction.
   function automatic logic [21:0] ref_outs(int s, logic mr);
      logic pcw = 0, pcz = 0, pcnz = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
      logic m2r = 0, rdst = 0, rw = 0, srca = 0, ill = 0;
      logic [1:0] srcb = 2'b00, aluop = 2'b00, pcsrc = 2'b00;
      case (s)
         0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
         1:  srcb = 2'b11;
         2:  begin srca = 1; srcb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin srca = 1; aluop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcz = 1; end
         9:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcnz = 1; end
         10: begin srca = 1; srcb = 2'b10; end
         11: rw = 1;
         12: begin pcw = 1; pcsrc = 2'b10; end
         13: ill = 1;
         default: ;
      endcase
      return {4'(s), pcw, pcz, pcnz, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop,
              pcsrc, ill};
   endfunction

   function automatic bit is_legal(logic [5:0] o);
      return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
                       6'b000010};
   endfunction

   task automatic push_cycle(int s, logic [5:0] o, logic mr);
      drv_q.push_back({o, mr});
      exp_q.push_back({ref_outs(s, mr), retired_m});
   endtask

   // Reference model: the cycle-by-cycle path of one instruction.
   task automatic gen_instr(logic [5:0] o, int fetch_wait, int mem_wait);
      for (int i = 0; i < fetch_wait; i++) push_cycle(0, 6'($urandom_range(0, 63)), 1'b0);
      push_cycle(0, 6'($urandom_range(0, 63)), 1'b1);
      push_cycle(1, o, 1'($urandom_range(0, 1)));
      case (o)
         6'b100011: begin
            push_cycle(2, o, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mem_wait; i++) push_cycle(3, o, 1'b0);
            push_cycle(3, o, 1'b1);
            push_cycle(4, o, 1'($urandom_range(0, 1)));
         end
         6'b101011: begin
            push_cycle(2, o, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mem_wait; i++) push_cycle(5, o, 1'b0);
            push_cycle(5, o, 1'b1);
         end
         6'b000000: begin push_cycle(6, o, 1'b1); push_cycle(7, o, 1'b0); end
         6'b000100: push_cycle(8, o, 1'($urandom_range(0, 1)));
         6'b000101: push_cycle(9, o, 1'($urandom_range(0, 1)));
         6'b001000: begin push_cycle(10, o, 1'b0); push_cycle(11, o, 1'b1); end
         6'b000010: push_cycle(12, o, 1'($urandom_range(0, 1)));
         default:   push_cycle(13, o, 1'($urandom_range(0, 1)));
      endcase
      if (is_legal(o)) retired_m = retired_m + 1;
   endtask

   task automatic check(string name, logic [53:0] act, logic [53:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got state=%0d ctrl=%h retired=%0d, expected state=%0d ctrl=%h retired=%0d",
                  name, act[53:50], act[49:32], act[31:0], exp[53:50], exp[49:32], exp[31:0]);
      end
   endtask

   // driver: one queued input pair per cycle, applied just after the edge
   task automatic run_driver();
      while (drv_q.size() > 0) begin
         {op, memReady} = drv_q.pop_front();
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: compares the full output vector every cycle mid-period
   task automatic run_monitor();
      int cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check($sformatf("cycle%0d", cyc), act_vec, exp_q.pop_front());
         cyc++;
      end
   endtask

   initial begin
      logic [5:0] legal_ops [7];
      logic [5:0] o;
      legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
      reset = 1'b1;
      op = 6'b100011;
      memReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("in_reset", act_vec, '0);
      end

      gen_instr(6'b100011, 0, 0);
      gen_instr(6'b000100, 0, 0);
      gen_instr(6'b101011, 2, 3);
      gen_instr(6'b111111, 0, 0);
      gen_instr(6'b000010, 0, 0);
      gen_instr(6'b000101, 0, 0);
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            do o = 6'($urandom_range(0, 63)); while (is_legal(o));
         end else begin
            o = legal_ops[$urandom_range(0, 6)];
         end
         gen_instr(o, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      @(posedge clk);
      #1;
      reset = 1'b0;
      fork
         run_driver();
         run_monitor();
      join

      // asynchronous reset in the middle of a stalled load
      op = 6'b100011;
      memReady = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      memReady = 1'b0;
      #2;
      check("memrd_before_reset", act_vec, {ref_outs(3, 1'b0), retired_m});
      reset = 1'b1;
      #1;
      check("async_reset", act_vec, '0);
      @(posedge clk);
      #1;
      check("reset_held", act_vec, '0);
      reset = 1'b0;
      memReady = 1'b1;
      @(negedge clk);
      check("fetch_after_reset", act_vec, {ref_outs(0, 1'b1), 32'd0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
